// File: rtl/periph_pkg.sv
// Shared peripheral definitions: register offsets,
// TCON bit positions and a bus address-match helper.
package periph_pkg;

   localparam logic [31:0] OFS_TH      = 32'd0;
   localparam logic [31:0] OFS_TL      = 32'd4;
   localparam logic [31:0] OFS_TCON    = 32'd8;
   localparam logic [31:0] OFS_SYSTICK = 32'd20;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IS = 2;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_TH,
      REG_TL,
      REG_TCON,
      REG_SYSTICK
   } reg_sel_e;

   // Word-granular match; byte lane bits are ignored.
   function automatic logic addr_hit(
      input logic [31:0] addr,
      input logic [31:0] base,
      input logic [31:0] ofs
   );
      logic [31:0] target;
      target = base + ofs;
      return addr[31:2] == target[31:2];
   endfunction

endpackage

// File: rtl/peripheral_timer_if.sv
// Data-bus bundle between the core (master) and the timer
// (slave); IRQ travels with the bus back to the core.
interface peripheral_timer_if;

   logic        MemRd;
   logic        MemWr;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        IRQ;

   modport master (
      output MemRd, MemWr, Addr, WriteData,
      input  ReadData, IRQ
   );

   modport slave (
      input  MemRd, MemWr, Addr, WriteData,
      output ReadData, IRQ
   );

endinterface

// File: rtl/timer_prescaler.sv
// Divides the core clock by PRESCALE while enabled;
// the count holds its value while disabled.
module timer_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Tick on the last count; wrap, advance or hold.
   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q;
      if (enable) begin
         if (cnt_q == LAST) begin
            tick  = 1'b1;
            cnt_d = 16'd0;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= 16'd0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/peripheral_timer.sv
// Memory-mapped interval timer: TH reload, TL counter, TCON.
// Define TIMER_SYSTICK_EN to add the free-running SYSTICK.
module peripheral_timer
   import periph_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          PRESCALE  = 1
) (
   input  logic               clk,
   input  logic               reset,
   peripheral_timer_if.slave  bus
);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic        tick;
   logic        ovf;
   reg_sel_e    sel;
   logic        wr_th, wr_tl, wr_tcon;
   logic        unused_addr;

   assign unused_addr = ^bus.Addr[1:0];

   timer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_presc (
      .clk    (clk),
      .reset  (reset),
      .enable (tcon_q[TCON_EN]),
      .tick   (tick)
   );

   assign ovf = tick && (tl_q == 32'hFFFF_FFFF);

   // Address decode to a single register select.
   always_comb begin
      sel = REG_NONE;
      unique case (1'b1)
         addr_hit(bus.Addr, BASE_ADDR, OFS_TH):
            sel = REG_TH;
         addr_hit(bus.Addr, BASE_ADDR, OFS_TL):
            sel = REG_TL;
         addr_hit(bus.Addr, BASE_ADDR, OFS_TCON):
            sel = REG_TCON;
         addr_hit(bus.Addr, BASE_ADDR, OFS_SYSTICK):
            sel = REG_SYSTICK;
         default:
            sel = REG_NONE;
      endcase
   end

   assign wr_th   = bus.MemWr && (sel == REG_TH);
   assign wr_tl   = bus.MemWr && (sel == REG_TL);
   assign wr_tcon = bus.MemWr && (sel == REG_TCON);

`ifdef TIMER_SYSTICK_EN
   logic [31:0] systick_q;

   // Free-running cycle counter, read-only from the bus.
   always_ff @(posedge clk) begin
      if (!reset) systick_q <= 32'd0;
      else        systick_q <= systick_q + 32'd1;
   end
`endif

   // Next state: bus writes win over count/reload on TL;
   // a same-cycle overflow still sets status on TCON write.
   always_comb begin
      th_d   = th_q;
      tl_d   = tl_q;
      tcon_d = tcon_q;
      if (tick) begin
         if (ovf) tl_d = th_q;
         else     tl_d = tl_q + 32'd1;
      end
      if (ovf && tcon_q[TCON_IE]) tcon_d[TCON_IS] = 1'b1;
      if (wr_th) th_d = bus.WriteData;
      if (wr_tl) tl_d = bus.WriteData;
      if (wr_tcon) begin
         tcon_d[TCON_EN] = bus.WriteData[TCON_EN];
         tcon_d[TCON_IE] = bus.WriteData[TCON_IE];
         tcon_d[TCON_IS] = bus.WriteData[TCON_IS]
                         | (ovf & bus.WriteData[TCON_IE]);
      end
   end

   // Register file with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         th_q   <= 32'd0;
         tl_q   <= 32'd0;
         tcon_q <= 3'd0;
      end else begin
         th_q   <= th_d;
         tl_q   <= tl_d;
         tcon_q <= tcon_d;
      end
   end

   // Zero-latency read mux; unselected or idle reads give 0.
   always_comb begin
      bus.ReadData = 32'd0;
      if (bus.MemRd) begin
         unique case (sel)
            REG_TH:      bus.ReadData = th_q;
            REG_TL:      bus.ReadData = tl_q;
            REG_TCON:    bus.ReadData = {29'd0, tcon_q};
`ifdef TIMER_SYSTICK_EN
            REG_SYSTICK: bus.ReadData = systick_q;
`else
            REG_SYSTICK: bus.ReadData = 32'd0;
`endif
            default:     bus.ReadData = 32'd0;
         endcase
      end
   end

   assign bus.IRQ = tcon_q[TCON_IS] & tcon_q[TCON_IE];

endmodule

// File: doc/peripheral_timer.md
# peripheral_timer

Memory-mapped interval timer for the single-cycle MIPS core; the sole source of the `IRQ` input consumed by the instruction decoder and controller. It holds a reload value (TH), a counting register (TL) and a control/status register (TCON) on the data bus at `BASE_ADDR`. On each TL overflow it reloads TL from TH and, when enabled, raises an interrupt. The interrupt stays pending until software clears it from the handler.

## Interface
- `BASE_ADDR`, 32'h4000_0000, byte address of TH; TL at +4, TCON at +8, SYSTICK at +20 (only with macro)
- `PRESCALE`, 1, core clocks per TL increment; legal range 1..65535
- `clk`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `MemRd`  in  1  bus read strobe
- `MemWr`  in  1  bus write strobe
- `Addr`  in  32  byte address; decoded on `Addr[31:2]`, `Addr[1:0]` ignored
- `WriteData`  in  32  write data
- `ReadData`  out  32  combinational read data
- `IRQ`  out  1  interrupt request, level, = TCON[2] & TCON[1]

## Operation
- Reset (reset=0 at an edge): TH=0, TL=0, TCON=0, prescale count=0, SYSTICK=0, so IRQ=0 and ReadData=0. Reset mid-count discards all state and any pending interrupt.
- TCON bits: [0] count enable, [1] interrupt enable, [2] interrupt status. Bits [31:3] read 0.
- Prescaler: counts 0..PRESCALE-1 while TCON[0]=1 and produces a tick when it equals PRESCALE-1, then wraps to 0. PRESCALE=1 gives a tick every enabled cycle. It holds its value while TCON[0]=0.
- On a tick with TL != 32'hFFFF_FFFF, TL <= TL+1.
- On a tick with TL == 32'hFFFF_FFFF (overflow), TL <= TH. If TCON[1]=1, TCON[2] <= 1.
- Writes (MemWr=1, address match) update the register at the clock edge. A TL write overrides a same-cycle increment or reload. A TH write does not affect the same-cycle reload, which uses the old TH.
- A TCON write sets bits [1:0] to WriteData[1:0]. Bit 2 next = WriteData[2] | (overflow & new TCON[1]). A same-cycle overflow therefore cannot be lost; software clears status by writing bit 2 = 0.
- Reads: when MemRd=1 and the address matches, ReadData = the current register value (pre-edge). Otherwise ReadData=0. Unmapped offsets read 0 and ignore writes.
- If MemRd and MemWr are both 1, the read returns the old value and the write takes effect at the edge.

## Timing
- IRQ is purely decoded from registers. It rises in the cycle after the overflow edge and falls in the cycle after the clearing write.
- With PRESCALE=P and TH=R, the period between overflows is (2^32 − R)·P cycles.
- The write-to-effect latency is 1 edge. Reads have zero latency.

## Configuration
- `TIMER_SYSTICK_EN` defined: adds SYSTICK, a free-running 32-bit counter at +20. It increments every cycle regardless of TCON, wraps 0xFFFF_FFFF→0, is read-only (writes ignored) and resets to 0.
- Not defined: no SYSTICK register; offset +20 reads 0.

## Structure
- Shared package `periph_pkg`: register offsets (TH=0, TL=4, TCON=8, SYSTICK=20) and TCON bit indices, reused by the bus decoder and other peripherals.
- One sub-module, `timer_prescaler`: parameter PRESCALE, inputs clk/reset/enable, output tick.
- The top level contains the register file, the address decode and the IRQ logic.

## Test plan
- Reset with TH/TL nonzero, then release: all registers read 0, IRQ=0, and TL stays 0 for 10 cycles.
- PRESCALE=1; write TH=TL=0xFFFF_FFFD, then TCON=3. After edges 1, 2, 3 TL reads FE, FF, FD; TCON reads 7 and IRQ=1 after edge 3.
- With IRQ pending, write TCON=3: IRQ drops the next cycle and counting continues. Then write TCON=1 and let TL overflow: TCON[2] stays 0 and IRQ stays 0.
- TCON write of 3 in the same cycle as an overflow: TCON reads 7 afterwards and IRQ=1. A TL write of 0x10 in the same cycle as an increment reads 0x10.
- PRESCALE=4, TL=0, TCON=1: TL reads 1 after 4 cycles and 3 after 12 cycles. Clearing TCON[0] freezes both TL and the prescaler.
- With `TIMER_SYSTICK_EN`: SYSTICK reads N after N cycles from reset, ignores a write of 0x1234, and reads 0 after a mid-run reset.
